// File: rtl/rgb_breath_seq.sv
// Rainbow sequencer for three breathing PWM channels (R, G, B).
// Each colour in turn ramps up until its STT edge, ramps down for a timed
// interval, then goes dark for a gap before the next colour starts.
module rgb_breath_seq #(
    parameter int DOWN_CLKS = 12002760,
    parameter int GAP_CLKS  = 1200000,
    parameter int UP_TMO    = 16777215
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       en_i,
    input  logic [2:0] stt_i,
    output logic [2:0] flag_o,
    output logic [2:0] oe_o,
    output logic [1:0] ch_o,
    output logic       cyc_done_o,
    output logic       err_o
);

    typedef enum logic [1:0] {IDLE, UP, DOWN, GAP} state_t;

    // Terminal counts, precomputed at timer width
    localparam logic [24:0] UP_LAST   = 25'(UP_TMO - 1);
    localparam logic [24:0] DOWN_LAST = 25'(DOWN_CLKS - 1);
    localparam logic [24:0] GAP_LAST  = 25'(GAP_CLKS - 1);

    state_t      state_q, state_d;
    logic [1:0]  ch_q, ch_d;
    logic [24:0] timer_q, timer_d;
    logic [2:0]  stt_q;
    logic [2:0]  flag_q, flag_d;
    logic [2:0]  oe_q, oe_d;
    logic        cyc_q, cyc_d;
    logic        err_q, err_d;
    logic [2:0]  rise;
    logic        rise_ch;
    logic [2:0]  sel;

    // Rising edge of STT on the active channel only; other channels ignored
    always_comb begin
        rise    = stt_i & ~stt_q;
        rise_ch = 1'b0;
        case (ch_q)
            2'd0:    rise_ch = rise[0];
            2'd1:    rise_ch = rise[1];
            2'd2:    rise_ch = rise[2];
            default: rise_ch = 1'b0;
        endcase
    end

    // Next state, channel, timer and flags; outputs derived from the new state
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        err_d   = err_q;
        cyc_d   = 1'b0;
        timer_d = timer_q + 25'd1;
        if (ch_q == 2'd3) begin
            // Unreachable channel index: fall back to a clean start
            state_d = IDLE;
            ch_d    = 2'd0;
            timer_d = '0;
        end else if (!en_i) begin
            state_d = IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = UP;
                    timer_d = '0;
                end
                UP: begin
                    if (rise_ch) begin
                        state_d = DOWN;
                        timer_d = '0;
                    end else if (timer_q == UP_LAST) begin
                        err_d   = 1'b1;
                        state_d = DOWN;
                        timer_d = '0;
                    end
                end
                DOWN: begin
                    if (timer_q == DOWN_LAST) begin
                        state_d = GAP;
                        timer_d = '0;
                    end
                end
                GAP: begin
                    if (timer_q == GAP_LAST) begin
                        state_d = UP;
                        timer_d = '0;
                        ch_d    = (ch_q == 2'd2) ? 2'd0 : ch_q + 2'd1;
                        cyc_d   = (ch_q == 2'd2);
                    end
                end
                default: begin
                    state_d = IDLE;
                    ch_d    = 2'd0;
                    timer_d = '0;
                end
            endcase
        end

        case (ch_d)
            2'd0:    sel = 3'b001;
            2'd1:    sel = 3'b010;
            2'd2:    sel = 3'b100;
            default: sel = 3'b000;
        endcase
        oe_d   = (state_d == UP || state_d == DOWN) ? sel : 3'b000;
        flag_d = (state_d == UP) ? sel : 3'b000;
    end

    // State and registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            ch_q    <= 2'd0;
            timer_q <= '0;
            stt_q   <= 3'b000;
            flag_q  <= 3'b000;
            oe_q    <= 3'b000;
            cyc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            timer_q <= timer_d;
            stt_q   <= stt_i;
            flag_q  <= flag_d;
            oe_q    <= oe_d;
            cyc_q   <= cyc_d;
            err_q   <= err_d;
        end
    end

    assign flag_o     = flag_q;
    assign oe_o       = oe_q;
    assign ch_o       = ch_q;
    assign cyc_done_o = cyc_q;
    assign err_o      = err_q;

endmodule

// File: doc/rgb_breath_seq.md
Name: rgb_breath_seq

Overview:
- Sequencer that sits directly upstream of the three per-colour breathing PWM channels (R, G, B).
- Drives each channel's FLAG (ramp direction) and OE (channel run enable) and consumes each channel's STT pulse.
- Produces a rainbow pattern: each colour in turn breathes up, breathes down, goes dark, then the next colour starts.
- Breathe-up completion is taken from STT. Breathe-down duration is timed internally, because the PWM channel gives no down-ramp status.

Parameters:
- DOWN_CLKS, 12002760, clocks FLAG is held 0 in DOWN; matches one full channel ramp, (3464+1)*3464.
- GAP_CLKS, 1200000, dark clocks between colours (50 ms at 24 MHz).
- UP_TMO, 16777215, max clocks allowed in UP before timeout.

Ports:
- CLK  in  1  system clock, 24 MHz
- _RST  in  1  asynchronous active-low reset
- EN  in  1  run enable; level-sensitive
- STT  in  3  channel STT inputs, bit0=R, bit1=G, bit2=B; synchronous to CLK
- FLAG  out  3  per-channel FLAG; 1=ramp up, 0=ramp down
- OE  out  3  per-channel _OE drive; 1=channel runs, 0=channel forced dark
- CH  out  2  active channel index: 0=R, 1=G, 2=B
- CYC_DONE  out  1  one-clock pulse when B finishes its GAP
- ERR  out  1  sticky UP-timeout flag; cleared only by reset

Behaviour:
- Clocking and reset: one clock; reset is asynchronous, active-low. All state and outputs are registered.
- Reset values: state=IDLE, FLAG=3'b000, OE=3'b000, CH=0, CYC_DONE=0, ERR=0, timer=0, stt_q=3'b000.
- STT edge detection: stt_q <= STT every clock. rise = STT & ~stt_q. Only rise[CH] is acted on; rises on other bits are ignored.
- Timer: 25-bit, cleared to 0 on every state entry, increments by 1 each clock in UP, DOWN and GAP.
- States:
  - IDLE: OE=0, FLAG=0. If EN=1, go to UP with CH unchanged.
  - UP: OE[CH]=1, FLAG[CH]=1; other bits 0.
    - If rise[CH]=1, go to DOWN.
    - Else, if timer==UP_TMO-1, set ERR=1 and go to DOWN.
    - If both occur in the same cycle, rise wins and ERR is not set.
  - DOWN: OE[CH]=1, FLAG[CH]=0. When timer==DOWN_CLKS-1, go to GAP.
  - GAP: OE=0, FLAG=0. When timer==GAP_CLKS-1:
    - CH <= (CH==2) ? 0 : CH+1, and go to UP.
    - If CH was 2, CYC_DONE=1 for exactly that clock.
- Output update: FLAG and OE change on the same edge as the state transition, so they are registered against the new state.
- EN deassert: EN=0 in any non-IDLE state forces IDLE on the next edge. OE and FLAG clear, and CH keeps its value. On EN=1, the same colour restarts at UP.
- STT level: the STT level is ignored; only the edge matters. An STT level already high on entry to UP does not complete UP.
- Illegal values: CH=3 and illegal state encodings recover to IDLE with CH=0.
- Overlap: at most one OE bit is high at any time.
- Reset mid-operation: outputs return to reset values immediately, asynchronously.

Test Plan (bench overrides DOWN_CLKS=20, GAP_CLKS=5, UP_TMO=100):
1. Reset release with EN=1, then a 1-clock pulse on STT[0] 10 clocks after entering UP:
   - Exactly 1 clock after entering UP: OE=001, FLAG=001.
   - After the STT[0] pulse: OE=001, FLAG=000 for 20 clocks.
   - Then OE=000 for 5 clocks, then CH=1 with OE=010, FLAG=010.
2. Full cycle with STT[CH] pulsed in each UP:
   - CH sequence is 0,1,2,0.
   - CYC_DONE is high exactly 1 clock, coincident with CH 2->0.
   - OE is never more than one-hot.
3. EN=1, no STT:
   - After 100 clocks in UP, ERR=1 and DOWN is entered.
   - ERR stays 1 through later cycles and until _RST.
4. STT[1] and STT[2] pulses while CH=0 in UP:
   - No transition.
   - A later STT[0] rise advances to DOWN normally.
5. EN dropped during DOWN on CH=1:
   - Next clock: OE=000, FLAG=000, CH=1.
   - EN re-raised: UP on CH=1 with the timer restarted.
6. _RST asserted mid-GAP, between clock edges:
   - Outputs go to reset values immediately, without waiting for a clock edge.
   - After release with EN=1, sequencing restarts at CH=0 in UP.
